// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control FSM for the RV32I subset datapath (add, addi, lw,
//   sw, lui). One shared memory port is used for both instruction fetch and
//   data access. The controller drives the datapath control set, the IR/PC
//   write strobes and the memory address select. It also halts on an
//   illegal instruction or on a memory access that takes too long.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   inst       in  32   IR contents (stable from DECODE until next fetch)
//   mem_ready  in   1   memory completes the current access this cycle
//   ImmSel     out  2   00 I-imm, 01 S-imm, 10 U-imm
//   RegWEn     out  1   register file write enable
//   Bsel       out  1   ALU B operand: 0 rs2, 1 imm
//   ALUSel     out  3   ALU op
//   MemRW      out  2   10 read, 01 write, 00 idle
//   WBSel      out  1   writeback source: 1 ALU, 0 memory
//   AuipcSel   out  1   ALU A operand select for U-type
//   IRWrite    out  1   load IR from memory read data
//   PCWrite    out  1   PC <= PC+4
//   AddrSel    out  1   memory address: 0 PC, 1 ALU result register
//   Halted     out  1   FSM is in HALT
//   State      out  3   current state (debug)
module multicycle_ctrl #(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [2:0]  ALU_ADD     = 3'b101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  output logic [1:0]  ImmSel,
  output logic        RegWEn,
  output logic        Bsel,
  output logic [2:0]  ALUSel,
  output logic [1:0]  MemRW,
  output logic        WBSel,
  output logic        AuipcSel,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        AddrSel,
  output logic        Halted,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b101
  } state_e;

  localparam int             CW       = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b10;
  localparam logic [1:0] MEM_WRITE = 2'b01;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_add, is_addi, is_lw, is_sw, is_lui, is_legal, is_mem;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0);
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_lui   = (opcode == 7'b0110111);
  assign is_legal = is_add | is_addi | is_lw | is_sw | is_lui;
  assign is_mem   = is_lw | is_sw;

  // Register/immediate fields belong to the datapath, not the controller.
  logic unused_inst;
  assign unused_inst = ^{inst[24:15], inst[11:7]};

  // Decoded control values shared by EXEC, MEM and WB.
  logic [1:0] dec_imm;
  logic       dec_bsel, dec_auipc, dec_wbsel;

  assign dec_imm   = is_sw ? 2'b01 : (is_lui ? 2'b10 : 2'b00);
  assign dec_bsel  = ~is_add;
  assign dec_auipc = is_lui;
  assign dec_wbsel = ~(is_lw | is_sw);

  // ---------------------------------------------------------------------
  // Memory wait / timeout
  // ---------------------------------------------------------------------
  logic waiting, timeout;

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  // mem_ready on the limit cycle wins, since waiting already requires !mem_ready.
  assign timeout = waiting && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_mem)        state_d = S_MEM;
        else if (is_legal) state_d = S_WB;
        else               state_d = S_HALT;
      end
      S_MEM: begin
        if (mem_ready)    state_d = is_lw ? S_WB : S_FETCH;
        else if (timeout) state_d = S_HALT;
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Any state change is an entry into a new state, so the wait count
  // restarts at zero for every FETCH and MEM visit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_q + CW'(1);
  end

  // ---------------------------------------------------------------------
  // Outputs (Moore on state, Mealy on inst / mem_ready)
  // ---------------------------------------------------------------------
  always_comb begin
    ImmSel   = 2'b00;
    RegWEn   = 1'b0;
    Bsel     = 1'b0;
    ALUSel   = ALU_ADD;
    MemRW    = MEM_IDLE;
    WBSel    = 1'b0;
    AuipcSel = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    AddrSel  = 1'b0;
    Halted   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        MemRW   = MEM_READ;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_EXEC, S_MEM, S_WB: begin
        ImmSel   = dec_imm;
        Bsel     = dec_bsel;
        AuipcSel = dec_auipc;
        WBSel    = dec_wbsel;
        if (state_q == S_MEM) begin
          AddrSel = 1'b1;
          MemRW   = is_lw ? MEM_READ : (is_sw ? MEM_WRITE : MEM_IDLE);
        end
        if (state_q == S_WB) RegWEn = 1'b1;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase

    // Reset must silence the memory port at once, not at the next edge.
    if (!rst_n) begin
      ImmSel   = 2'b00;
      RegWEn   = 1'b0;
      Bsel     = 1'b0;
      ALUSel   = ALU_ADD;
      MemRW    = MEM_IDLE;
      WBSel    = 1'b0;
      AuipcSel = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      AddrSel  = 1'b0;
      Halted   = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int         TO  = 16;
  localparam logic [2:0] ADD = 3'b101;
  localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WB = 3'd4, HA = 3'd5;

  logic        clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [1:0]  ImmSel, MemRW;
  logic [2:0]  ALUSel, State;
  logic        RegWEn, Bsel, WBSel, AuipcSel, IRWrite, PCWrite, AddrSel, Halted;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .ALU_ADD(ADD)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
    .ImmSel(ImmSel), .RegWEn(RegWEn), .Bsel(Bsel), .ALUSel(ALUSel),
    .MemRW(MemRW), .WBSel(WBSel), .AuipcSel(AuipcSel), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .AddrSel(AddrSel), .Halted(Halted), .State(State)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  typedef enum int {K_ADD, K_ADDI, K_LW, K_SW, K_LUI, K_ILL} kind_e;
  typedef struct packed {
    logic [1:0] imm; logic rwe; logic bsel; logic [2:0] alu; logic [1:0] mrw;
    logic wbs; logic aui; logic irw; logic pcw; logic asel; logic hlt;
  } ctl_t;
  typedef struct { logic [2:0] st; logic mr; } step_t;

  step_t q[$];

  function automatic kind_e classify(input logic [31:0] i);
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'd0) return K_ADD;
    if (op == 7'h13 && f3 == 3'd0)               return K_ADDI;
    if (op == 7'h03 && f3 == 3'd2)               return K_LW;
    if (op == 7'h23 && f3 == 3'd2)               return K_SW;
    if (op == 7'h37)                             return K_LUI;
    return K_ILL;
  endfunction

  function automatic ctl_t idle_ctl();
    ctl_t c;
    c = '0; c.alu = ADD;
    return c;
  endfunction

  // Control values the spec prescribes for a given phase of an instruction.
  function automatic ctl_t expect_ctl(input logic [2:0] st, input kind_e k, input logic mr);
    ctl_t c;
    c = idle_ctl();
    if (st == FE) begin
      c.mrw = 2'b10; c.irw = mr; c.pcw = mr;
    end else if (st == EX || st == ME || st == WB) begin
      c.imm  = (k == K_SW) ? 2'b01 : ((k == K_LUI) ? 2'b10 : 2'b00);
      c.bsel = (k != K_ADD);
      c.aui  = (k == K_LUI);
      c.wbs  = !(k == K_LW || k == K_SW);
      if (st == ME) begin c.asel = 1'b1; c.mrw = (k == K_LW) ? 2'b10 : 2'b01; end
      if (st == WB) c.rwe = 1'b1;
    end else if (st == HA) begin
      c.hlt = 1'b1;
    end
    return c;
  endfunction

  function automatic ctl_t obs_ctl();
    return {ImmSel, RegWEn, Bsel, ALUSel, MemRW, WBSel, AuipcSel, IRWrite, PCWrite, AddrSel, Halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Append a memory-wait phase; returns 1 when it ends in a timeout.
  task automatic add_wait(input logic [2:0] st, input int w, output bit to);
    if (w >= TO) begin
      for (int i = 0; i < TO; i++) q.push_back('{st, 1'b0});
      to = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) q.push_back('{st, 1'b0});
      q.push_back('{st, 1'b1});
      to = 1'b0;
    end
  endtask

  // Expected cycle-by-cycle state trace of one instruction.
  task automatic build(input kind_e k, input int wf, input int wm, input int hold, output bit h);
    bit to;
    h = 1'b0;
    add_wait(FE, wf, to);
    if (!to) begin
      q.push_back('{DE, 1'($urandom)});
      if (k == K_ILL) to = 1'b1;
      else begin
        q.push_back('{EX, 1'($urandom)});
        if (k == K_LW || k == K_SW) add_wait(ME, wm, to);
        if (!to && k != K_SW) q.push_back('{WB, 1'($urandom)});
      end
    end
    if (to) begin
      for (int i = 0; i < hold; i++) q.push_back('{HA, 1'($urandom)});
      h = 1'b1;
    end
  endtask

  // Called at a negedge; leaves at a negedge.
  task automatic play(input logic [31:0] ins, input kind_e k, input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.mr; inst = ins;
      #1;
      check({tag, " state"}, 32'(State), 32'(s.st));
      check({tag, " ctl"}, 32'(obs_ctl()), 32'(expect_ctl(s.st, k, s.mr)));
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    check({tag, " rst state"}, 32'(State), 32'(FE));
    check({tag, " rst ctl"}, 32'(obs_ctl()), 32'(idle_ctl()));
    @(negedge clk);
    check({tag, " rst hold ctl"}, 32'(obs_ctl()), 32'(idle_ctl()));
    rst_n = 1'b1;
  endtask

  task automatic run(input logic [31:0] ins, input int wf, input int wm, input int hold, input string tag);
    kind_e k; bit h;
    k = classify(ins);
    build(k, wf, wm, hold, h);
    play(ins, k, tag);
    if (h) do_reset(tag);
  endtask

  function automatic logic [31:0] gen(input int sel);
    logic [31:0] r;
    r = $urandom;
    case (sel)
      0: return {7'b0, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
      1: return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
      2: return {r[31:20], r[19:15], 3'b010, r[11:7], 7'b0000011};
      3: return {r[31:25], r[24:20], r[19:15], 3'b010, r[11:7], 7'b0100011};
      4: return {r[31:12], 7'b0110111} | {20'b0, r[11:7], 7'b0};
      5: return {7'b0100000, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
      6: return {r[31:20], r[19:15], 3'b001 | {r[14:13], 1'b0}, r[11:7], 7'b0010011};
      7: return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0000011};
      default: return r;
    endcase
  endfunction

  initial begin
    @(negedge clk);
    do_reset("init");

    run(32'h002081B3, 0, 0, 0,  "add");
    run(32'h0040A283, 0, 3, 0,  "lw_wait");
    run(32'h0020A423, 0, 0, 0,  "sw");
    run(32'h123453B7, 0, 0, 0,  "lui");
    run(32'hFFFFFFFF, 0, 0, 20, "illegal");
    run(32'h002081B3, 16, 0, 3, "fetch_timeout");
    run(32'h002081B3, 15, 0, 0, "fetch_limit_ready");
    run(32'h0040A283, 0, 16, 3, "mem_timeout");
    run(32'h0040A283, 0, 15, 0, "mem_limit_ready");

    // Reset asserted in the middle of a store's MEM phase.
    begin
      bit to;
      add_wait(FE, 0, to);
      q.push_back('{DE, 1'b0});
      q.push_back('{EX, 1'b0});
      q.push_back('{ME, 1'b0});
      q.push_back('{ME, 1'b0});
      play(32'h0020A423, K_SW, "sw_pre_rst");
      mem_ready = 1'b0;
      #1;
      check("sw mid MemRW", 32'(MemRW), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("async rst state", 32'(State), 32'(FE));
      check("async rst ctl", 32'(obs_ctl()), 32'(idle_ctl()));
      @(negedge clk);
      rst_n = 1'b1;
      run(32'h002081B3, 1, 0, 0, "post_rst_add");
    end

    for (int n = 0; n < 80; n++) begin
      int wf, wm;
      wf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      wm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      run(gen(int'($urandom_range(0, 8))), wf, wm, int'($urandom_range(1, 4)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
